mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit_pkg.sv | 47 ++++
 rtl/mem_access_unit_align.sv | 55 +++++
 rtl/mem_access_unit.sv | 154 +++++++++++++++
 tb/tb_mem_access_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared types for the memory access unit and data bus
//   mem_op_t    : load / store selector
//   msize_t     : access size (1, 2, 4 or 8 bytes)
//   dbus_req_t  : request to the data cache (valid, addr, size, strobe, data)
//   dbus_resp_t : response from the data cache (addr_ok, data_ok, data)
package mem_access_unit_pkg;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } mem_op_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  // An access is aligned when its byte offset is a multiple of its size.
  function automatic logic is_misaligned(input msize_t size, input logic [2:0] off);
    logic mis;
    mis = 1'b0;
    case (size)
      MSIZE2:  mis = off[0];
      MSIZE4:  mis = (off[1:0] != 2'b00);
      MSIZE8:  mis = (off != 3'b000);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// rtl/mem_access_unit_align.sv - byte-lane alignment and load extension (combinational)
//   size, off, is_unsigned : access descriptor (off = addr[2:0])
//   wdata                  : right-aligned store data
//   rdata                  : raw 64-bit word from the data cache
//   strobe                 : byte-lane write enables
//   wdata_lane             : store data shifted into its byte lanes
//   rdata_ext              : load data shifted down, truncated and extended to 64 bits
//   misalign               : access offset is not a multiple of its size
module mem_access_unit_align
  import mem_access_unit_pkg::*;
(
  input  msize_t      size,
  input  logic [2:0]  off,
  input  logic        is_unsigned,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  strobe,
  output logic [63:0] wdata_lane,
  output logic [63:0] rdata_ext,
  output logic        misalign
);

  logic [5:0]  bit_shift;
  logic [63:0] rdata_sh;

  assign bit_shift  = {off, 3'b000};
  assign wdata_lane = wdata << bit_shift;
  assign rdata_sh   = rdata >> bit_shift;
  assign misalign   = is_misaligned(size, off);

  always_comb begin
    strobe = 8'h00;
    case (size)
      MSIZE1:  strobe = 8'h01 << off;
      MSIZE2:  strobe = 8'h03 << off;
      MSIZE4:  strobe = 8'h0F << off;
      default: strobe = 8'hFF;
    endcase
  end

  // MSIZE8 returns the full word, so signedness has no effect there.
  always_comb begin
    rdata_ext = 64'd0;
    case (size)
      MSIZE1:  rdata_ext = is_unsigned ? {56'd0, rdata_sh[7:0]}
                                       : {{56{rdata_sh[7]}}, rdata_sh[7:0]};
      MSIZE2:  rdata_ext = is_unsigned ? {48'd0, rdata_sh[15:0]}
                                       : {{48{rdata_sh[15]}}, rdata_sh[15:0]};
      MSIZE4:  rdata_ext = is_unsigned ? {32'd0, rdata_sh[31:0]}
                                       : {{32{rdata_sh[31]}}, rdata_sh[31:0]};
      default: rdata_ext = rdata_sh;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-entry load/store unit between memory stage and data cache
//   clk, reset                  : clock, synchronous active-high reset
//   in_valid/in_ready           : op handshake from the pipeline
//   in_op/in_size/in_unsigned   : op descriptor
//   in_addr/in_wdata            : byte address, right-aligned store data
//   flush                       : discard the in-flight op's result
//   out_valid/out_ready         : result handshake to writeback
//   out_rdata/out_misalign      : extended load data, misaligned exception flag
//   dreq/dresp                  : data cache request / response
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int UNCACHED_BIT = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  mem_op_t           in_op,
  input  msize_t            in_size,
  input  logic              in_unsigned,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [63:0]       in_wdata,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_rdata,
  output logic              out_misalign,
  output dbus_req_t         dreq,
  input  dbus_resp_t        dresp
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // UNCACHED_BIT is only a label for the address map; it must lie inside the address.
  if (ADDR_W < 64) begin : g_bad_addr_w
    $error("mem_access_unit: ADDR_W must be at least 64");
  end
  if (UNCACHED_BIT >= ADDR_W) begin : g_bad_uncached_bit
    $error("mem_access_unit: UNCACHED_BIT outside address");
  end

  logic [1:0] state;
  logic       killed;
  mem_op_t    op_q;
  msize_t     size_q;
  logic       uns_q;
  logic [2:0] off_q;

  msize_t      al_size;
  logic [2:0]  al_off;
  logic        al_uns;
  logic [7:0]  al_strobe;
  logic [63:0] al_wdata;
  logic [63:0] al_rdata;
  logic        al_misalign;

  logic unused_addr_ok;
  assign unused_addr_ok = dresp.addr_ok;

  assign in_ready = (state == S_IDLE);

  // One aligner serves both ends: in IDLE it builds the request from the
  // incoming op, in BUSY it extends the response using the registered op.
  assign al_size = (state == S_IDLE) ? in_size        : size_q;
  assign al_off  = (state == S_IDLE) ? in_addr[2:0]   : off_q;
  assign al_uns  = (state == S_IDLE) ? in_unsigned    : uns_q;

  mem_access_unit_align u_align (
    .size        (al_size),
    .off         (al_off),
    .is_unsigned (al_uns),
    .wdata       (in_wdata),
    .rdata       (dresp.data),
    .strobe      (al_strobe),
    .wdata_lane  (al_wdata),
    .rdata_ext   (al_rdata),
    .misalign    (al_misalign)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      killed       <= 1'b0;
      op_q         <= MEM_LOAD;
      size_q       <= MSIZE1;
      uns_q        <= 1'b0;
      off_q        <= 3'd0;
      dreq         <= '0;
      out_valid    <= 1'b0;
      out_rdata    <= 64'd0;
      out_misalign <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!flush && in_valid) begin
            op_q   <= in_op;
            size_q <= in_size;
            uns_q  <= in_unsigned;
            off_q  <= in_addr[2:0];
            if (al_misalign) begin
              state        <= S_HOLD;
              out_valid    <= 1'b1;
              out_misalign <= 1'b1;
              out_rdata    <= 64'd0;
            end else begin
              state       <= S_BUSY;
              killed      <= 1'b0;
              dreq.valid  <= 1'b1;
              dreq.addr   <= in_addr[63:0];
              dreq.size   <= in_size;
              dreq.strobe <= (in_op == MEM_STORE) ? al_strobe : 8'h00;
              dreq.data   <= (in_op == MEM_STORE) ? al_wdata  : 64'd0;
            end
          end
        end

        // The cache cannot abandon a transaction, so a flush here only marks
        // the result as dead; the request stays up until data_ok.
        S_BUSY: begin
          if (dresp.data_ok) begin
            dreq <= '0;
            if (killed || flush) begin
              state <= S_IDLE;
            end else begin
              state        <= S_HOLD;
              out_valid    <= 1'b1;
              out_misalign <= 1'b0;
              out_rdata    <= (op_q == MEM_LOAD) ? al_rdata : 64'd0;
            end
            killed <= 1'b0;
          end else if (flush) begin
            killed <= 1'b1;
          end
        end

        S_HOLD: begin
          if (flush || out_ready) begin
            state        <= S_IDLE;
            out_valid    <= 1'b0;
            out_misalign <= 1'b0;
            out_rdata    <= 64'd0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  mem_op_t     in_op;
  msize_t      in_size;
  logic        in_unsigned;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_rdata;
  logic        out_misalign;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;

  int errors = 0;
  int checks = 0;

  mem_access_unit #(.ADDR_W(64), .UNCACHED_BIT(31)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_size      (in_size),
    .in_unsigned  (in_unsigned),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rdata    (out_rdata),
    .out_misalign (out_misalign),
    .dreq         (dreq),
    .dresp        (dresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op for exactly one accepting edge.
  task automatic issue(input mem_op_t op, input msize_t sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wd);
    in_valid    = 1'b1;
    in_op       = op;
    in_size     = sz;
    in_unsigned = uns;
    in_addr     = addr;
    in_wdata    = wd;
    step();
    in_valid    = 1'b0;
  endtask

  task automatic respond(input logic [63:0] data);
    dresp.data    = data;
    dresp.data_ok = 1'b1;
    step();
    dresp.data_ok = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int stable;
    reset = 1'b1; in_valid = 1'b0; in_op = MEM_LOAD; in_size = MSIZE1;
    in_unsigned = 1'b0; in_addr = 64'd0; in_wdata = 64'd0; flush = 1'b0;
    out_ready = 1'b0; dresp = '0;
    step(); step();
    check("rst_in_ready",  64'(in_ready), 64'd1);
    check("rst_dreq",      64'(dreq.valid) | dreq.addr | dreq.data | 64'(dreq.strobe), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_rdata",     out_rdata, 64'd0);
    check("rst_misalign",  64'(out_misalign), 64'd0);
    reset = 1'b0;
    step();

    // Byte store with a long miss
    issue(MEM_STORE, MSIZE1, 1'b0, 64'h8000_0003, 64'hAB);
    check("st1_valid",  64'(dreq.valid), 64'd1);
    check("st1_strobe", 64'(dreq.strobe), 64'h08);
    check("st1_data",   dreq.data, 64'h0000_0000_AB00_0000);
    check("st1_addr",   dreq.addr, 64'h8000_0003);
    check("st1_size",   64'(dreq.size), 64'(MSIZE1));
    check("st1_busy_rdy", 64'(in_ready), 64'd0);
    stable = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (dreq.valid && dreq.strobe == 8'h08 && dreq.data == 64'h0000_0000_AB00_0000 &&
          dreq.addr == 64'h8000_0003 && !out_valid)
        stable++;
    end
    check("st1_miss_hold", 64'(stable), 64'd40);
    respond(64'hDEAD_BEEF_DEAD_BEEF);
    check("st1_drop",   64'(dreq.valid), 64'd0);
    check("st1_ovalid", 64'(out_valid), 64'd1);
    check("st1_rdata",  out_rdata, 64'd0);
    consume();
    check("st1_idle",   64'(in_ready), 64'd1);
    check("st1_oclr",   64'(out_valid), 64'd0);

    // Signed halfword load, hit in the first BUSY cycle
    issue(MEM_LOAD, MSIZE2, 1'b0, 64'h8000_0006, 64'd0);
    check("lh_dvalid", 64'(dreq.valid), 64'd1);
    check("lh_strobe", 64'(dreq.strobe), 64'd0);
    check("lh_ov_early", 64'(out_valid), 64'd0);
    respond(64'h8001_1234_5678_9ABC);
    check("lh_ovalid", 64'(out_valid), 64'd1);
    check("lh_rdata",  out_rdata, 64'hFFFF_FFFF_FFFF_8001);
    check("lh_rdy0",   64'(in_ready), 64'd0);
    step();
    check("lh_hold",   out_rdata, 64'hFFFF_FFFF_FFFF_8001);
    check("lh_hold_rdy", 64'(in_ready), 64'd0);
    consume();
    check("lh_idle",   64'(in_ready), 64'd1);

    // Same, zero-extended
    issue(MEM_LOAD, MSIZE2, 1'b1, 64'h8000_0006, 64'd0);
    respond(64'h8001_1234_5678_9ABC);
    check("lhu_rdata", out_rdata, 64'h0000_0000_0000_8001);
    consume();

    // Signed byte load at offset 5
    issue(MEM_LOAD, MSIZE1, 1'b0, 64'h8000_0005, 64'd0);
    step();
    respond(64'h0000_F700_0000_0000);
    check("lb_rdata", out_rdata, 64'hFFFF_FFFF_FFFF_FFF7);
    consume();

    // Word load at offset 4, signed, positive value
    issue(MEM_LOAD, MSIZE4, 1'b0, 64'h8000_0004, 64'd0);
    respond(64'h7654_3210_89AB_CDEF);
    check("lw_rdata", out_rdata, 64'h0000_0000_7654_3210);
    consume();

    // Misaligned word load: no bus request
    issue(MEM_LOAD, MSIZE4, 1'b0, 64'h8000_0002, 64'd0);
    check("mis_dvalid", 64'(dreq.valid), 64'd0);
    check("mis_ovalid", 64'(out_valid), 64'd1);
    check("mis_flag",   64'(out_misalign), 64'd1);
    check("mis_rdata",  out_rdata, 64'd0);
    consume();
    check("mis_clr",    64'(out_misalign), 64'd0);

    // Flush during BUSY: request held, result dropped
    issue(MEM_LOAD, MSIZE8, 1'b0, 64'h8000_0008, 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_dvalid", 64'(dreq.valid), 64'd1);
    step(); step();
    check("fl_still",  64'(dreq.valid), 64'd1);
    respond(64'h1111_2222_3333_4444);
    check("fl_ovalid", 64'(out_valid), 64'd0);
    check("fl_rdy",    64'(in_ready), 64'd1);
    check("fl_drop",   64'(dreq.valid), 64'd0);

    // Flush together with data_ok
    issue(MEM_LOAD, MSIZE8, 1'b0, 64'h8000_0010, 64'd0);
    flush = 1'b1;
    respond(64'h5555_6666_7777_8888);
    flush = 1'b0;
    check("fldo_ovalid", 64'(out_valid), 64'd0);
    check("fldo_rdy",    64'(in_ready), 64'd1);

    // Uncached doubleword store
    issue(MEM_STORE, MSIZE8, 1'b0, 64'h1000_0000, 64'h0123_4567_89AB_CDEF);
    check("sd_strobe", 64'(dreq.strobe), 64'hFF);
    check("sd_data",   dreq.data, 64'h0123_4567_89AB_CDEF);
    step(); step();
    respond(64'hFFFF_FFFF_FFFF_FFFF);
    check("sd_ovalid", 64'(out_valid), 64'd1);
    check("sd_rdata",  out_rdata, 64'd0);
    check("sd_mis",    64'(out_misalign), 64'd0);
    consume();

    // Reset while BUSY
    issue(MEM_LOAD, MSIZE8, 1'b1, 64'h8000_0020, 64'd0);
    check("rb_busy", 64'(dreq.valid), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rb_drop", 64'(dreq.valid), 64'd0);
    check("rb_rdy",  64'(in_ready), 64'd1);

    // Doubleword load after reset recovery
    issue(MEM_LOAD, MSIZE8, 1'b1, 64'h8000_0020, 64'd0);
    respond(64'h8877_6655_4433_2211);
    check("ld_rdata", out_rdata, 64'h8877_6655_4433_2211);
    consume();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
